// File: rtl/fwd_hazard_unit.sv
// Operand bypass and load-use hazard detection from a shift-register scoreboard of in-flight writers.
// Latency: selects, operands and stall are combinational on scoreboard state; the scoreboard advances every cycle.
// Backpressure: stall holds the issuing instruction and puts a bubble into entry 0; flush overrides stall.
module fwd_hazard_unit #(
    parameter int WIDTH      = 32,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    parameter int AW         = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       issue_valid,
    input  logic                       issue_wr_en,
    input  logic [AW-1:0]              issue_rd,
    input  logic                       issue_is_load,
    input  logic                       flush,
    input  logic [NUM_SRC-1:0]         src_used,
    input  logic [NUM_SRC*AW-1:0]      src_addr,
    input  logic [NUM_SRC*WIDTH-1:0]   src_ori,
    input  logic [DEPTH*WIDTH-1:0]     stage_data,
    output logic [NUM_SRC*WIDTH-1:0]   src_out,
    output logic [NUM_SRC*(DEPTH+1)-1:0] fwd_sel,
    output logic                       stall,
    output logic [15:0]                stall_cnt
);

    localparam int SELW = DEPTH + 1;
    localparam int KW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic          vld;
        logic          wr_en;
        logic [AW-1:0] rd;
        logic          is_load;
    } sb_entry_t;

    sb_entry_t          sb_q [DEPTH];
    sb_entry_t          issue_ent;
    logic               issue_take;
    logic [NUM_SRC-1:0] hazard;

    assign issue_ent  = '{vld: 1'b1, wr_en: issue_wr_en, rd: issue_rd, is_load: issue_is_load};
    assign stall      = issue_valid & ~flush & (|hazard);
    assign issue_take = issue_valid & ~stall & ~flush;

    // Entries never hold: a stalled or flushed slot simply becomes a bubble at entry 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            sb_q[0] <= issue_take ? issue_ent : '0;
            for (int k = 1; k < DEPTH; k++) begin
                sb_q[k] <= sb_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    always_comb begin
        logic [AW-1:0]   addr;
        logic            found;
        logic [KW-1:0]   idx;
        logic [SELW-1:0] sel;
        src_out = '0;
        fwd_sel = '0;
        hazard  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            addr  = src_addr[i*AW +: AW];
            found = 1'b0;
            idx   = '0;
            // Scan oldest to youngest so the lowest matching index is what remains.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (src_used[i] && sb_q[k].vld && sb_q[k].wr_en &&
                    (sb_q[k].rd == addr) && (addr != '0)) begin
                    found = 1'b1;
                    idx   = KW'(k);
                end
            end
            sel = '0;
            if (found) begin
                sel[idx] = 1'b1;
                src_out[i*WIDTH +: WIDTH] = stage_data[int'(idx)*WIDTH +: WIDTH];
                hazard[i] = sb_q[idx].is_load && (int'(idx) < LOAD_READY);
            end else begin
                sel[DEPTH] = 1'b1;
                src_out[i*WIDTH +: WIDTH] = src_ori[i*WIDTH +: WIDTH];
            end
            fwd_sel[i*SELW +: SELW] = sel;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench: default-config vector table, a 3-source/4-deep load stall sequence,
// and stall counter saturation plus asynchronous reset in the middle of a stall.
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default configuration: NUM_SRC=2, DEPTH=3, LOAD_READY=1
    logic        iv0, wen0, ld0, fl0;
    logic [4:0]  rd0;
    logic [1:0]  used0;
    logic [9:0]  addr0;
    logic [63:0] ori0;
    logic [95:0] sd0;
    logic [63:0] out0;
    logic [7:0]  sel0;
    logic        st0;
    logic [15:0] cnt0;

    // NUM_SRC=3, DEPTH=4, LOAD_READY=2
    logic         iv1, wen1, ld1, fl1;
    logic [4:0]   rd1;
    logic [2:0]   used1;
    logic [14:0]  addr1;
    logic [95:0]  ori1;
    logic [127:0] sd1;
    logic [95:0]  out1;
    logic [14:0]  sel1;
    logic         st1;
    logic [15:0]  cnt1;

    // NUM_SRC=1, DEPTH=16, LOAD_READY=16: a self-dependent load stalls 16 of every 17 cycles
    logic         iv2, wen2, ld2, fl2;
    logic [4:0]   rd2;
    logic [0:0]   used2;
    logic [4:0]   addr2;
    logic [31:0]  ori2;
    logic [511:0] sd2;
    logic [31:0]  out2;
    logic [16:0]  sel2;
    logic         st2;
    logic [15:0]  cnt2;

    fwd_hazard_unit u0 (
        .clk(clk), .rst_n(rst_n), .issue_valid(iv0), .issue_wr_en(wen0), .issue_rd(rd0),
        .issue_is_load(ld0), .flush(fl0), .src_used(used0), .src_addr(addr0), .src_ori(ori0),
        .stage_data(sd0), .src_out(out0), .fwd_sel(sel0), .stall(st0), .stall_cnt(cnt0)
    );

    fwd_hazard_unit #(.WIDTH(32), .NUM_SRC(3), .DEPTH(4), .LOAD_READY(2), .AW(5)) u1 (
        .clk(clk), .rst_n(rst_n), .issue_valid(iv1), .issue_wr_en(wen1), .issue_rd(rd1),
        .issue_is_load(ld1), .flush(fl1), .src_used(used1), .src_addr(addr1), .src_ori(ori1),
        .stage_data(sd1), .src_out(out1), .fwd_sel(sel1), .stall(st1), .stall_cnt(cnt1)
    );

    fwd_hazard_unit #(.WIDTH(32), .NUM_SRC(1), .DEPTH(16), .LOAD_READY(16), .AW(5)) u2 (
        .clk(clk), .rst_n(rst_n), .issue_valid(iv2), .issue_wr_en(wen2), .issue_rd(rd2),
        .issue_is_load(ld2), .flush(fl2), .src_used(used2), .src_addr(addr2), .src_ori(ori2),
        .stage_data(sd2), .src_out(out2), .fwd_sel(sel2), .stall(st2), .stall_cnt(cnt2)
    );

    typedef struct {
        logic        iv, wen, ld, fl;
        logic [4:0]  rd;
        logic [1:0]  used;
        logic [9:0]  addr;
        logic [63:0] ori;
        logic [95:0] sd;
        logic [63:0] e_out;
        logic [7:0]  e_sel;
        logic        e_stall;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(input logic iv, input logic wen, input logic [4:0] rd,
                                input logic ld, input logic fl, input logic [1:0] used,
                                input logic [4:0] a1, input logic [4:0] a0,
                                input logic [31:0] o1, input logic [31:0] o0,
                                input logic [95:0] sd, input logic [31:0] x1,
                                input logic [31:0] x0, input logic [7:0] sel,
                                input logic st, input logic [15:0] cnt);
        vec_t v;
        v.iv = iv; v.wen = wen; v.rd = rd; v.ld = ld; v.fl = fl; v.used = used;
        v.addr = {a1, a0}; v.ori = {o1, o0}; v.sd = sd;
        v.e_out = {x1, x0}; v.e_sel = sel; v.e_stall = st; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic u1_chk(input string tag, input logic e_st, input logic [14:0] e_sel,
                          input logic [95:0] e_out, input logic [15:0] e_cnt);
        chk({tag, "_stall"}, 128'(st1), 128'(e_st));
        chk({tag, "_sel"},   128'(sel1), 128'(e_sel));
        chk({tag, "_out"},   128'(out1), 128'(e_out));
        chk({tag, "_cnt"},   128'(cnt1), 128'(e_cnt));
    endtask

    logic [95:0] sa, sb;

    initial begin
        rst_n = 1'b0;
        iv0 = 0; wen0 = 0; ld0 = 0; fl0 = 0; rd0 = '0; used0 = '0; addr0 = '0; ori0 = '0; sd0 = '0;
        iv1 = 0; wen1 = 0; ld1 = 0; fl1 = 0; rd1 = '0; used1 = '0; addr1 = '0; ori1 = '0; sd1 = '0;
        iv2 = 0; wen2 = 0; ld2 = 0; fl2 = 0; rd2 = '0; used2 = '0; addr2 = '0; ori2 = '0; sd2 = '0;

        sa = {32'h30, 32'h20, 32'h10};
        sb = {32'h33, 32'h22, 32'h11};
        //        iv wen rd ld fl used  a1 a0  o1      o0      sd  x1      x0      sel    st cnt
        vt[0]  = mk(1, 1, 0, 0, 0, 2'b11, 2, 1, 32'hA2, 32'hA1, sa, 32'hA2, 32'hA1, 8'h88, 0, 0);
        vt[1]  = mk(1, 1, 3, 0, 0, 2'b11, 2, 1, 32'hA2, 32'hA1, sa, 32'hA2, 32'hA1, 8'h88, 0, 0);
        vt[2]  = mk(1, 1, 3, 0, 0, 2'b11, 0, 3, 32'h00, 32'hB0, sa, 32'h00, 32'h10, 8'h81, 0, 0);
        vt[3]  = mk(0, 0, 0, 0, 0, 2'b11, 3, 0, 32'h99, 32'h05, sb, 32'h11, 32'h05, 8'h18, 0, 0);
        vt[4]  = mk(0, 0, 0, 0, 0, 2'b10, 3, 3, 32'h99, 32'h07, sb, 32'h22, 32'h07, 8'h28, 0, 0);
        vt[5]  = mk(0, 0, 0, 0, 0, 2'b11, 9, 3, 32'h09, 32'h77, sb, 32'h09, 32'h33, 8'h84, 0, 0);
        vt[6]  = mk(1, 1, 5, 1, 0, 2'b11, 2, 1, 32'hA2, 32'hA1, sa, 32'hA2, 32'hA1, 8'h88, 0, 0);
        vt[7]  = mk(1, 1, 6, 0, 0, 2'b11, 2, 5, 32'hA2, 32'hA1, sa, 32'hA2, 32'h10, 8'h81, 1, 0);
        vt[8]  = mk(1, 1, 6, 0, 0, 2'b11, 2, 5, 32'hA2, 32'hA1, sa, 32'hA2, 32'h20, 8'h82, 0, 1);
        vt[9]  = mk(1, 1, 5, 1, 0, 2'b00, 2, 1, 32'hA2, 32'hA1, sa, 32'hA2, 32'hA1, 8'h88, 0, 1);
        vt[10] = mk(1, 1, 7, 0, 0, 2'b10, 2, 5, 32'hA2, 32'hA1, sa, 32'hA2, 32'hA1, 8'h88, 0, 1);
        vt[11] = mk(1, 1, 5, 1, 0, 2'b11, 2, 1, 32'hA2, 32'hA1, sa, 32'hA2, 32'hA1, 8'h88, 0, 1);
        vt[12] = mk(1, 1, 8, 0, 1, 2'b11, 2, 5, 32'hA2, 32'hA1, sa, 32'hA2, 32'h10, 8'h81, 0, 1);
        vt[13] = mk(0, 0, 0, 0, 0, 2'b11, 7, 8, 32'hA2, 32'h88, sa, 32'h30, 32'h88, 8'h48, 0, 1);
        vt[14] = mk(1, 1, 5, 1, 0, 2'b11, 2, 1, 32'hA2, 32'hA1, sa, 32'hA2, 32'hA1, 8'h88, 0, 1);
        vt[15] = mk(0, 0, 0, 0, 0, 2'b11, 2, 5, 32'hA2, 32'hA1, sa, 32'hA2, 32'h10, 8'h81, 0, 1);

        // Reset state
        repeat (2) next_cycle();
        used0 = 2'b11; addr0 = {5'd3, 5'd3}; ori0 = {32'h66, 32'h55}; sd0 = sa;
        #3;
        chk("rst_stall", 128'(st0), 128'(1'b0));
        chk("rst_cnt",   128'(cnt0), 128'(16'd0));
        chk("rst_sel",   128'(sel0), 128'(8'h88));
        chk("rst_out",   128'(out0), 128'({32'h66, 32'h55}));
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            next_cycle();
            iv0 = vt[i].iv; wen0 = vt[i].wen; rd0 = vt[i].rd; ld0 = vt[i].ld; fl0 = vt[i].fl;
            used0 = vt[i].used; addr0 = vt[i].addr; ori0 = vt[i].ori; sd0 = vt[i].sd;
            #4;
            chk($sformatf("v%0d_out", i),   128'(out0), 128'(vt[i].e_out));
            chk($sformatf("v%0d_sel", i),   128'(sel0), 128'(vt[i].e_sel));
            chk($sformatf("v%0d_stall", i), 128'(st0),  128'(vt[i].e_stall));
            chk($sformatf("v%0d_cnt", i),   128'(cnt0), 128'(vt[i].e_cnt));
        end
        next_cycle();
        iv0 = 0; wen0 = 0; ld0 = 0; fl0 = 0; used0 = '0;

        // Load in EX with LOAD_READY=2: two stall cycles, then forward from entry 2
        sd1 = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
        ori1 = {32'hC2, 32'hC1, 32'hC0};
        iv1 = 1; wen1 = 1; rd1 = 5'd5; ld1 = 1; used1 = 3'b000; addr1 = {5'd2, 5'd1, 5'd5};
        #4;
        u1_chk("u1_lw", 1'b0, {5'b10000, 5'b10000, 5'b10000}, {32'hC2, 32'hC1, 32'hC0}, 16'd0);
        next_cycle();
        rd1 = 5'd6; ld1 = 0; used1 = 3'b111;
        #4;
        u1_chk("u1_st1", 1'b1, {5'b10000, 5'b10000, 5'b00001}, {32'hC2, 32'hC1, 32'h1111}, 16'd0);
        next_cycle();
        #4;
        u1_chk("u1_st2", 1'b1, {5'b10000, 5'b10000, 5'b00010}, {32'hC2, 32'hC1, 32'h2222}, 16'd1);
        next_cycle();
        #4;
        u1_chk("u1_fwd", 1'b0, {5'b10000, 5'b10000, 5'b00100}, {32'hC2, 32'hC1, 32'h3333}, 16'd2);
        next_cycle();
        iv1 = 0; used1 = '0;
        #4;
        u1_chk("u1_idle", 1'b0, {5'b10000, 5'b10000, 5'b10000}, {32'hC2, 32'hC1, 32'hC0}, 16'd2);

        // Saturation: cycle c stalls unless c is a multiple of 17
        for (int c = 0; c <= 70000; c++) begin
            next_cycle();
            if (c == 0) begin
                iv2 = 1; wen2 = 1; ld2 = 1; rd2 = 5'd5; used2 = 1'b1; addr2 = 5'd5;
            end
            if (c == 170) begin
                #4;
                chk("sat_c170_cnt",   128'(cnt2), 128'(16'd160));
                chk("sat_c170_stall", 128'(st2),  128'(1'b0));
            end
            if (c == 171) begin
                #4;
                chk("sat_c171_stall", 128'(st2),  128'(1'b1));
                chk("sat_c171_sel",   128'(sel2), 128'(17'h00001));
            end
        end
        #4;
        chk("sat_stall", 128'(st2),  128'(1'b1));
        chk("sat_cnt",   128'(cnt2), 128'(16'hFFFF));

        // Asynchronous reset in the middle of a stall, no clock edge in between
        rst_n = 1'b0;
        #1;
        chk("arst_stall", 128'(st2),  128'(1'b0));
        chk("arst_cnt",   128'(cnt2), 128'(16'd0));
        chk("arst_sel",   128'(sel2), 128'(17'h10000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit for the 5-stage MIPS pipeline.
- Replaces the fixed 2-source, 2-stage forwarding mux.
- Keeps its own shift-register scoreboard of in-flight writers (EX, MEM, WB, ...) and computes per-source bypass selects.
- Forwards the youngest matching result, asserts stall on load-use hazards and counts stall cycles for performance monitoring.

Parameters:
- WIDTH, 32, data width of operands/results
- NUM_SRC, 2, number of source operands per issuing instruction
- DEPTH, 3, tracked in-flight stages (entry 0 = EX, 1 = MEM, 2 = WB, ...)
- LOAD_READY, 1, lowest entry index at which load data is valid in stage_data
- AW, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction in ID is valid
- issue_wr_en  in  1  ID instruction writes a register
- issue_rd  in  AW  destination register of ID instruction
- issue_is_load  in  1  ID instruction is a load
- flush  in  1  squash ID instruction (branch/jump redirect)
- src_used  in  NUM_SRC  per-source: operand actually read
- src_addr  in  NUM_SRC*AW  source register addresses, source i at [i*AW +: AW]
- src_ori  in  NUM_SRC*WIDTH  register-file read values
- stage_data  in  DEPTH*WIDTH  result at output of tracked entry k
- src_out  out  NUM_SRC*WIDTH  forwarded operands
- fwd_sel  out  NUM_SRC*(DEPTH+1)  one-hot select per source; bit DEPTH = register file
- stall  out  1  hold PC/IF/ID and inject bubble into EX
- stall_cnt  out  16  saturating count of stall cycles

Behaviour:
- Scoreboard entry k holds {valid, wr_en, rd, is_load}.
- Reset (async, rst_n=0): all entries invalid, stall_cnt=0. Combinational outputs then read: stall=0, src_out=src_ori, fwd_sel=register-file bit.
- Advance every clock:
  - entry k <= entry k-1 for k>=1.
  - entry 0 <= issue info if issue_valid & !stall & !flush; otherwise a bubble (valid=0).
  - Entries never hold; stall only inserts bubbles at entry 0.
  - The oldest entry falls off.
- Match for source i at entry k: src_used[i] & entry valid & wr_en & rd==src_addr[i] & src_addr[i]!=0.
- Forward priority: lowest matching k (youngest) wins. No match -> src_ori.
  - fwd_sel exactly one-hot at all times.
- Register 0: never matches. src_out = src_ori, which the register file returns as 0.
- Load-use hazard: the youngest match is a load at k < LOAD_READY.
  - stall=1; src_out for that source is don't-care but must still follow the select.
  - A load at k >= LOAD_READY forwards normally.
- stall = OR over sources of load-use hazard, gated by issue_valid & !flush. Purely combinational, zero latency.
- Stall duration: with LOAD_READY=L, a load immediately followed by a dependent instruction stalls exactly L - k cycles (default: 1 cycle for load in EX).
- stall_cnt increments on each clock edge where stall=1 and saturates at 16'hFFFF.
- flush and stall same cycle: flush wins; stall=0, bubble inserted.
- A write by an entry older than DEPTH-1 is assumed visible through the register file (write-before-read). The unit does not track it.
- Reset mid-stall: entries cleared immediately; stall drops asynchronously with rst_n.

Test Plan:
- Reset, then ADD r3 issued, next instr reads r3 as src0 -> fwd_sel[0]=EX bit, src_out0=stage_data[0]=0x0000_0010 in the cycle after issue.
- r3 written by entries 0 and 1 (0x11 / 0x22), src1=r3 -> src_out1=0x11 (youngest wins); src0=r0 with an entry writing r0 -> src_out0=src_ori0.
- LW r5 then ADD reading r5 -> stall=1 for exactly 1 cycle, entry 0 bubble. The following cycle forwards stage_data[1], stall_cnt=1.
- Same LW hazard but src_used=0 for that operand -> stall=0; with flush=1 on the dependent cycle -> stall=0, bubble injected.
- Force 70000 consecutive stall cycles -> stall_cnt saturates at 0xFFFF. Assert rst_n low mid-stall -> stall=0 and stall_cnt=0 immediately without a clock.
- NUM_SRC=3, DEPTH=4, LOAD_READY=2: load in EX with dependent instruction -> 2 stall cycles, then forward from entry 2.
